sum_frame_scheduler: RTL

Round-robin frame scheduler that shares one parallel 8-bit/128-sample summation datapath between up to four sample sources. It grants one source at a time, issues the single-cycle start pulse, streams exactly one frame of that source's samples into the accumulator, and waits for the accumulator's done strobe with a timeout. It then returns the 17-bit frame sum tagged with the source index. It sits between the sample-source front ends and the accumulator.

---
 rtl/sum_frame_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sum_frame_scheduler.sv
// Round-robin scheduler sharing one frame accumulator between up to four sample sources:
// grant, start pulse, stream one frame, wait for done (with timeout), report the tagged sum.
module sum_frame_scheduler #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int FRAME_LEN = 128,
    parameter int SW        = 17,
    parameter int TIMEOUT   = 64
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    en_mask,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rd_en,
    output logic               acc_start,
    output logic [DW-1:0]      acc_data,
    input  logic [SW-1:0]      acc_sum,
    input  logic               acc_done,
    output logic               res_valid,
    output logic [1:0]         res_id,
    output logic [SW-1:0]      res_sum,
    output logic               res_err,
    output logic               busy
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_REPORT} state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rd_en_q;
    logic            acc_start_q;
    logic [DW-1:0]   acc_data_q;
    logic            res_valid_q;
    logic [1:0]      res_id_q;
    logic [SW-1:0]   res_sum_q;
    logic            res_err_q;
    logic [1:0]      id_q;
    logic [1:0]      last_id_q;
    logic [CW-1:0]   sample_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_oh_d;
    logic            pick_vld_d;
    logic [1:0]      pick_id_d;
    logic [1:0]      cand;
    logic [DW-1:0]   src_arr [NREQ];

    assign elig = req & en_mask;

    // Search starts one past the last reported source, so every eligible source gets a turn.
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        pick_vld_d = 1'b0;
        pick_id_d  = '0;
        pick_oh_d  = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(last_id_q) + i) % NREQ);
            if (!pick_vld_d && elig[cand]) begin
                pick_vld_d      = 1'b1;
                pick_id_d       = cand;
                pick_oh_d[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src_arr[i] = src_data[i*DW +: DW];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            rd_en_q      <= '0;
            acc_start_q  <= 1'b0;
            acc_data_q   <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_sum_q    <= '0;
            res_err_q    <= 1'b0;
            id_q         <= '0;
            last_id_q    <= 2'(NREQ - 1);
            sample_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            acc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            acc_data_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        gnt_q       <= pick_oh_d;
                        id_q        <= pick_id_d;
                        acc_start_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    sample_cnt_q <= '0;
                    rd_en_q      <= gnt_q;
                    state_q      <= S_STREAM;
                end
                S_STREAM: begin
                    acc_data_q <= src_arr[id_q];
                    if (sample_cnt_q == CW'(FRAME_LEN - 1)) begin
                        rd_en_q   <= '0;
                        tmo_cnt_q <= '0;
                        state_q   <= S_WAIT;
                    end else begin
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    // A done strobe on the final timeout cycle still counts as a good result.
                    if (acc_done || (tmo_cnt_q == TW'(TIMEOUT - 1))) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                        res_err_q   <= !acc_done;
                        res_sum_q   <= acc_done ? acc_sum : '0;
                        gnt_q       <= '0;
                        state_q     <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    last_id_q <= id_q;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rd_en     = rd_en_q;
    assign acc_start = acc_start_q;
    assign acc_data  = acc_data_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
